// File: rtl/riscv_32_fetch_stage_if.sv
// riscv_32_fetch_stage_if
// Bundles every signal of the RV32 fetch stage apart from clk/rst.
//   Decode side : stall, redirect, redirect_pc (in); instr, instr_pc,
//                 instr_valid, pc (out)
//   Memory side : imem_req, imem_addr (out); imem_rvalid, imem_rdata (in)
// Handshake semantics:
//   - Decode: an instruction is transferred on every rising edge where
//     instr_valid=1 and stall=0 (stall acts as an inverted ready), unless
//     redirect is also high, in which case the instruction is flushed.
//   - Memory: imem_req is a one-cycle pulse carrying imem_addr; the memory
//     answers with exactly one imem_rvalid pulse some cycles later.  At most
//     one request is ever outstanding.
// modport master is the fetch stage, modport slave is its environment.
interface riscv_32_fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic [31:0] pc;

  modport master (
    input  stall, redirect, redirect_pc, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, instr, instr_pc, instr_valid, pc
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, pc
  );
endinterface

// File: rtl/riscv_32_fetch_stage.sv
// riscv_32_fetch_stage
// Instruction fetch stage of the 3-stage RV32 core.  Holds the PC, issues
// single-outstanding requests to a variable-latency instruction memory and
// presents a registered instruction (plus its PC) to the decoder.  A
// one-entry skid buffer catches a response that arrives while the decoder
// is stalled; redirect flushes everything and refetches from a new target.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous reset, active-high
//   bus     - riscv_32_fetch_stage_if.master (decode + imem signals)
//   state_o - current FSM state (debug observation)
module riscv_32_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                          clk,
  input  logic                          rst,
  riscv_32_fetch_stage_if.master        bus,
  output logic [1:0]                    state_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // issue request for pc
    WAIT  = 2'd1,  // request outstanding
    HOLD  = 2'd2,  // response parked in skid, waiting for the slot
    DROP  = 2'd3   // request outstanding but flushed; discard its response
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic consume;
  assign consume = instr_valid_q & ~bus.stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
      skid_q        <= 32'h0;
      skid_pc_q     <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      skid_q        <= skid_d;
      skid_pc_q     <= skid_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    skid_d        = skid_q;
    skid_pc_d     = skid_pc_q;

    // A consumed slot empties unless a load below refills it.
    if (consume) begin
      instr_valid_d = 1'b0;
      instr_d       = NOP_INSTR;
    end

    unique case (state_q)
      FETCH: state_d = WAIT;
      WAIT: begin
        if (bus.imem_rvalid) begin
          pc_d = pc_q + 32'd4;
          if (!instr_valid_q || consume) begin
            instr_d       = bus.imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = FETCH;
          end else begin
            // Slot occupied and stalled: park the word instead of losing it.
            skid_d    = bus.imem_rdata;
            skid_pc_d = pc_q;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (consume) begin
          instr_d       = skid_q;
          instr_pc_d    = skid_pc_q;
          instr_valid_d = 1'b1;
          state_d       = FETCH;
        end
      end
      DROP: begin
        if (bus.imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Redirect beats stall, rvalid and consume.  The skid is implicitly
    // emptied because we never return to HOLD from here.  If a request is
    // (or is still) in flight we must go to DROP to swallow its response.
    if (bus.redirect) begin
      pc_d          = bus.redirect_pc & ~32'd3;
      instr_valid_d = 1'b0;
      instr_d       = NOP_INSTR;
      unique case (state_q)
        FETCH:   state_d = DROP;
        WAIT:    state_d = bus.imem_rvalid ? FETCH : DROP;
        HOLD:    state_d = FETCH;
        DROP:    state_d = bus.imem_rvalid ? FETCH : DROP;
        default: state_d = FETCH;
      endcase
    end
  end

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_riscv_32_fetch_stage.sv
// tb_riscv_32_fetch_stage
// Bench for the RV32 fetch stage.  Memory holds word 0x1000+addr at every
// address.  The reference model is the architectural instruction stream:
// from a start PC the decoder must see pc, pc+4, pc+8 ... in order, each
// exactly once; a redirect or reset restarts the stream at the new target.
module tb_riscv_32_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int RUN_LEN = 512;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  riscv_32_fetch_stage_if bus ();

  riscv_32_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  logic [63:0] exp_q[$];  // {pc, instr}

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory model ----------------
  int          mem_lat = 1;
  bit          rand_lat = 1'b0;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= 32'h0;
      mem_busy        <= 1'b0;
      mem_cnt         <= 0;
      mem_addr        <= 32'h0;
    end else begin : mem_step
      int l;
      bus.imem_rvalid <= 1'b0;
      if (mem_busy) begin
        if (mem_cnt == 1) begin
          bus.imem_rvalid <= 1'b1;
          bus.imem_rdata  <= mem_addr + 32'h1000;
          mem_busy        <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
      if (bus.imem_req) begin
        l = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
        if (l == 1) begin
          bus.imem_rvalid <= 1'b1;
          bus.imem_rdata  <= bus.imem_addr + 32'h1000;
        end else begin
          mem_busy <= 1'b1;
          mem_cnt  <= l - 1;
          mem_addr <= bus.imem_addr;
        end
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic push_run(input logic [31:0] start);
    logic [31:0] a;
    for (int i = 0; i < RUN_LEN; i++) begin
      a = start + 32'(4 * i);
      exp_q.push_back({a, a + 32'h1000});
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      logic [63:0] e;
      if (!bus.instr_valid) begin
        checks++;
        if (bus.instr !== NOP) begin
          errors++;
          $display("FAIL nop_when_invalid: got %h expected %h", bus.instr, NOP);
        end
      end
      checks++;
      if (bus.imem_req && (mem_busy || bus.imem_rvalid)) begin
        errors++;
        $display("FAIL single_outstanding: req while busy=%0b rvalid=%0b", mem_busy, bus.imem_rvalid);
      end
      if (bus.instr_valid && !bus.stall && !bus.redirect) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_underflow: got pc %h instr %h expected nothing", bus.instr_pc, bus.instr);
        end else begin
          e = exp_q.pop_front();
          delivered++;
          if ({bus.instr_pc, bus.instr} !== e) begin
            errors++;
            $display("FAIL stream: got pc %h instr %h expected pc %h instr %h",
                     bus.instr_pc, bus.instr, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    push_run(32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    bus.redirect    = 1'b1;
    bus.redirect_pc = target;
    exp_q.delete();
    push_run(target & ~32'd3);
  endtask

  // Checks the current cycle first, then steps up to budget cycles.
  task automatic wait_req_addr(input logic [31:0] a, input int budget, input string name);
    bit found = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (bus.imem_req && bus.imem_addr == a) begin
        found = 1'b1;
        break;
      end
      if (i < budget) step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: no request to %h within %0d cycles (addr now %h)", name, a, budget, bus.imem_addr);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    bit prev_req;
    int d0;

    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_imem_addr", bus.imem_addr, 32'h0);
    chk("reset_instr", bus.instr, NOP);
    chk("reset_instr_pc", bus.instr_pc, 32'h0);
    chk("reset_instr_valid", {31'h0, bus.instr_valid}, 32'h0);

    // Zero-latency memory: sequential fetch addresses.
    mem_lat = 1;
    exp_q.delete();
    push_run(32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    wait_req_addr(32'h0, 0, "seq_addr_0");
    for (int k = 1; k < 6; k++) begin
      step();
      wait_req_addr(32'(4 * k), 2, "seq_addr");
    end
    repeat (10) step();

    // Stall held 6 cycles while 0x1004 is valid.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.instr_valid && bus.instr_pc == 32'h4) begin
        found = 1'b1;
        break;
      end
    end
    chk("stall_reach_pc4", {31'h0, found}, 32'h1);
    bus.stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("stall_instr", bus.instr, 32'h1004);
      chk("stall_instr_pc", bus.instr_pc, 32'h4);
      chk("stall_valid", {31'h0, bus.instr_valid}, 32'h1);
      if (i >= 2) chk("hold_no_req", {31'h0, bus.imem_req}, 32'h0);
      step();
    end
    bus.stall = 1'b0;
    step();
    chk("skid_instr", bus.instr, 32'h1008);
    chk("skid_instr_pc", bus.instr_pc, 32'h8);
    chk("skid_valid", {31'h0, bus.instr_valid}, 32'h1);
    chk("resume_req", {31'h0, bus.imem_req}, 32'h1);
    chk("resume_addr", bus.imem_addr, 32'hC);
    repeat (6) step();

    // Latency 3, redirect one cycle after the request to 8.
    mem_lat = 3;
    do_reset();
    step();
    wait_req_addr(32'h8, 30, "lat3_req8");
    step();
    redirect_to(32'h200);
    step();
    bus.redirect = 1'b0;
    chk("drop_pc", bus.pc, 32'h200);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_req) begin
        found = 1'b1;
        break;
      end
      chk("drop_invalid", {31'h0, bus.instr_valid}, 32'h0);
      step();
    end
    chk("drop_refetch_seen", {31'h0, found}, 32'h1);
    chk("drop_refetch_addr", bus.imem_addr, 32'h200);
    repeat (12) step();

    // Redirect with stall and rvalid in the same cycle.
    mem_lat = 1;
    bus.stall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.imem_rvalid && bus.instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("flush_setup", {31'h0, found}, 32'h1);
    redirect_to(32'h103);
    step();
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    chk("flush_instr", bus.instr, NOP);
    chk("flush_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("flush_req", {31'h0, bus.imem_req}, 32'h1);
    chk("flush_addr", bus.imem_addr, 32'h100);
    repeat (8) step();

    // PC wrap-around.
    redirect_to(32'hFFFF_FFFC);
    step();
    bus.redirect = 1'b0;
    wait_req_addr(32'hFFFF_FFFC, 6, "wrap_req_top");
    step();
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.imem_req) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("wrap_next_seen", {31'h0, found}, 32'h1);
    chk("wrap_next_addr", bus.imem_addr, 32'h0);
    repeat (6) step();

    // Randomized stall, latency and redirects.
    rand_lat = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      step();
      bus.stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) redirect_to($urandom);
      else bus.redirect = 1'b0;
    end
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    repeat (10) step();
    chk("random_progress", {31'h0, (delivered - d0) > 100}, 32'h1);
    rand_lat = 1'b0;

    // Asynchronous reset in WAIT with a valid instruction.
    mem_lat = 3;
    do_reset();
    bus.stall = 1'b1;
    prev_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (prev_req && !bus.imem_req && bus.instr_valid) begin
        found = 1'b1;
        break;
      end
      prev_req = bus.imem_req;
    end
    chk("areset_setup", {31'h0, found}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("areset_pc", bus.pc, 32'h0);
    chk("areset_instr", bus.instr, NOP);
    chk("areset_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("areset_instr_pc", bus.instr_pc, 32'h0);
    do_reset();
    #1;
    chk("post_reset_req", {31'h0, bus.imem_req}, 32'h1);
    chk("post_reset_addr", bus.imem_addr, 32'h0);
    d0 = delivered;
    repeat (20) step();
    chk("post_reset_progress", {31'h0, delivered > d0}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_32_fetch_stage.md
Name: riscv_32_fetch_stage

Overview:
- Instruction fetch stage of the 3-stage RV32 CPU; sits directly upstream of the instruction decoder.
- Holds the PC and issues single-outstanding requests to instruction memory, which has variable response latency.
- Presents a registered instruction word and its PC to the decode stage, with stall backpressure, a one-entry skid buffer and redirect/flush on taken branches and jumps.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, word driven on instr when instr_valid=0 (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- stall  input  1  downstream cannot accept the current instruction this cycle.
- redirect  input  1  taken branch/jump; flush and refetch.
- redirect_pc  input  32  new fetch target; bits [1:0] ignored (forced 0).
- imem_req  output  1  fetch request, one cycle pulse.
- imem_addr  output  32  fetch address (= pc).
- imem_rvalid  input  1  response valid.
- imem_rdata  input  32  response instruction word.
- instr  output  32  instruction to decoder; NOP_INSTR when invalid.
- instr_pc  output  32  PC of instr.
- instr_valid  output  1  instr holds a real instruction.
- pc  output  32  next fetch address.

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC, state=FETCH.
  - instr=NOP_INSTR, instr_pc=0, instr_valid=0, skid empty.
  - imem_addr=RESET_PC.
  - The memory shares rst, so no stale response survives reset; imem_rvalid outside WAIT/DROP is ignored.
- imem_req=1 only in state FETCH; imem_addr=pc always. One request is outstanding at most.
- Consume event: instr_valid=1 and stall=0 in the same cycle.
- States:
  - FETCH: assert imem_req → WAIT.
  - WAIT, no rvalid: stay.
  - WAIT, rvalid with the output slot free (instr_valid=0 or consume this cycle):
    - instr<=rdata, instr_pc<=pc, instr_valid<=1.
    - pc<=pc+4 → FETCH.
  - WAIT, rvalid with the output slot occupied and stall=1:
    - skid<=rdata, skid_pc<=pc, pc<=pc+4 → HOLD.
  - HOLD: on consume, instr<=skid, instr_pc<=skid_pc, instr_valid<=1, skid empty → FETCH; otherwise stay.
  - DROP: wait for rvalid, discard the data → FETCH.
- Consume with no new data loaded: instr_valid<=0, instr<=NOP_INSTR.
- Redirect has highest priority in every state; it overrides stall, rvalid and consume:
  - pc<=redirect_pc & ~3.
  - instr_valid<=0, instr<=NOP_INSTR, skid emptied.
  - Next state:
    - From FETCH (request issued this cycle): DROP.
    - From WAIT without rvalid: DROP.
    - From WAIT with rvalid: FETCH, and the response is discarded.
    - From HOLD or DROP-with-rvalid: FETCH.
    - From DROP without rvalid: stay in DROP.
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0.
- Throughput: at most one instruction per 2 cycles (FETCH + ≥1 WAIT cycle).
- Instruction order is preserved. No instruction is lost or duplicated under any stall pattern.

Test Plan:
- Zero-latency memory (rvalid on the cycle after req), word at addr k = 0x1000+k, stall=0:
  - After reset release, imem_addr sequence 0,4,8,...
  - instr sequence 0x1000,0x1004,... each valid one cycle, instr_pc matching.
- Stall held 6 cycles while instr 0x1004 (pc 4) is valid:
  - instr stays 0x1004; word 0x1008 is captured in skid; no imem_req while in HOLD.
  - After release, instr=0x1008 pc=8 next cycle, then fetch resumes at 0xC.
- Memory latency 3, redirect to 0x200 one cycle after the request to addr 8:
  - Response for addr 8 is discarded (DROP).
  - Next imem_addr=0x200; first valid instr_pc=0x200; instr_valid=0 in between.
- Redirect to 0x103 with stall=1 and rvalid in the same cycle:
  - Flush wins: instr=0x0000_0013, instr_valid=0.
  - Next fetch addr=0x100.
- Redirect to 0xFFFF_FFFC:
  - Fetch at 0xFFFF_FFFC, then next imem_addr=0x0000_0000.
- Assert rst mid-WAIT with instr_valid=1:
  - Outputs immediately (asynchronously) show pc=0, instr=0x13, instr_valid=0.
  - imem_req=1 with addr 0 on the first clock after release.
